// File: rtl/crc_pkg.sv
// crc_pkg: shared types, bit-reflection helper and common CRC presets for
// the streaming CRC engine.
//   state_t  : engine FSM states
//   reflect  : reverse the low 'width' bits of a value (upper bits cleared)
//   presets  : polynomial / init / xor-out / reflection for common CRCs
package crc_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int unsigned MAX_CRC_W = 64;

    // Bit-reverse the low 'width' bits of value; bits at and above width are zero.
    function automatic logic [63:0] reflect(input logic [63:0] value, input int unsigned width);
        logic [63:0] r;
        r = '0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i < width) begin
                r[6'(i)] = value[6'(width - 1 - i)];
            end
        end
        return r;
    endfunction

    // CRC-32 (IEEE 802.3)
    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
    localparam bit          CRC32_REFLECT = 1'b1;

    // CRC-32/MPEG-2
    localparam logic [31:0] CRC32_MPEG2_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_MPEG2_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_MPEG2_XOR_OUT = 32'h00000000;
    localparam bit          CRC32_MPEG2_REFLECT = 1'b0;

    // CRC-16/CCITT-FALSE
    localparam logic [15:0] CRC16_CCITT_POLY    = 16'h1021;
    localparam logic [15:0] CRC16_CCITT_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_CCITT_XOR_OUT = 16'h0000;
    localparam bit          CRC16_CCITT_REFLECT = 1'b0;

    // CRC-8 (SMBus)
    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam logic [7:0] CRC8_INIT    = 8'h00;
    localparam logic [7:0] CRC8_XOR_OUT = 8'h00;
    localparam bit         CRC8_REFLECT = 1'b0;

endpackage

// File: rtl/crc_fold_step.sv
// crc_fold_step: combinational fold of one BITS_PER_CYC-bit chunk into a CRC
// register, fully unrolled.
//   crc      in  CRC_W         current register (reflected domain when REFLECT_IN)
//   chunk    in  BITS_PER_CYC  message bits; chunk[0] first when REFLECT_IN,
//                              chunk[BITS_PER_CYC-1] first otherwise
//   crc_next out CRC_W         register after folding all chunk bits
module crc_fold_step
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W        = 32,
    parameter int unsigned      BITS_PER_CYC = 8,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(CRC32_POLY),
    parameter bit               REFLECT_IN   = 1'b1
) (
    input  logic [CRC_W-1:0]        crc,
    input  logic [BITS_PER_CYC-1:0] chunk,
    output logic [CRC_W-1:0]        crc_next
);

    localparam logic [CRC_W-1:0] POLY_R = CRC_W'(reflect(64'(POLY), CRC_W));

    logic [CRC_W-1:0] c;
    logic             fb;

    // Reflected mode is the mirror image: shift right, feedback from bit 0.
    always_comb begin
        c  = crc;
        fb = 1'b0;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (REFLECT_IN) begin
                fb = c[0] ^ chunk[i];
                c  = (c >> 1) ^ (fb ? POLY_R : '0);
            end else begin
                fb = c[CRC_W-1] ^ chunk[BITS_PER_CYC-1-i];
                c  = (c << 1) ^ (fb ? POLY : '0);
            end
        end
        crc_next = c;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// crc_stream_engine: parametrised CRC over a valid/ready word stream,
// BITS_PER_CYC message bits folded per clock, finalised CRC on a
// valid/ready result port.
//   clk, rst            clock, synchronous active-high reset
//   clear_i             abort current message / pending result, reload INIT
//   in_data/in_valid/in_last/in_ready   message word stream
//   crc_o/out_valid/out_ready           finalised CRC, held until accepted
//   busy_o              engine not idle or a message is partially accumulated
module crc_stream_engine
    import crc_pkg::*;
#(
    parameter int unsigned      CRC_W        = 32,
    parameter int unsigned      DATA_W       = 32,
    parameter int unsigned      BITS_PER_CYC = 8,
    parameter logic [CRC_W-1:0] POLY         = CRC_W'(CRC32_POLY),
    parameter logic [CRC_W-1:0] INIT         = CRC_W'(CRC32_INIT),
    parameter logic [CRC_W-1:0] XOR_OUT      = CRC_W'(CRC32_XOR_OUT),
    parameter bit               REFLECT_IN   = 1'b1,
    parameter bit               REFLECT_OUT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [CRC_W-1:0]  crc_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy_o
);

    localparam int unsigned CHUNKS = DATA_W / BITS_PER_CYC;
    localparam int unsigned CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHUNKS - 1);
    // The register lives in the reflected domain when input is reflected.
    localparam logic [CRC_W-1:0] INIT_REG =
        REFLECT_IN ? CRC_W'(reflect(64'(INIT), CRC_W)) : INIT;

    if ((DATA_W % 8 != 0) || (DATA_W % BITS_PER_CYC != 0) || (BITS_PER_CYC > DATA_W) ||
        (CRC_W > MAX_CRC_W) || (CRC_W < 8)) begin : g_bad_params
        $fatal(1, "crc_stream_engine: illegal CRC_W/DATA_W/BITS_PER_CYC combination");
    end

    state_t                  state;
    logic [CRC_W-1:0]        crc_q;
    logic [CRC_W-1:0]        crc_step;
    logic [DATA_W-1:0]       sreg;
    logic                    last_q;
    logic [CNT_W-1:0]        cnt;
    logic [BITS_PER_CYC-1:0] chunk;

    // Next chunk comes from the low end when reflected, high end otherwise.
    assign chunk = REFLECT_IN ? sreg[BITS_PER_CYC-1:0] : sreg[DATA_W-1 -: BITS_PER_CYC];

    crc_fold_step #(
        .CRC_W        (CRC_W),
        .BITS_PER_CYC (BITS_PER_CYC),
        .POLY         (POLY),
        .REFLECT_IN   (REFLECT_IN)
    ) u_fold (
        .crc      (crc_q),
        .chunk    (chunk),
        .crc_next (crc_step)
    );

    // Map register back to normal form, apply output reflection and XOR.
    function automatic logic [CRC_W-1:0] finalize(input logic [CRC_W-1:0] r);
        logic [CRC_W-1:0] normal;
        logic [CRC_W-1:0] shaped;
        normal = REFLECT_IN  ? CRC_W'(reflect(64'(r), CRC_W)) : r;
        shaped = REFLECT_OUT ? CRC_W'(reflect(64'(normal), CRC_W)) : normal;
        return shaped ^ XOR_OUT;
    endfunction

    // Engine FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            crc_q     <= INIT_REG;
            sreg      <= '0;
            last_q    <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            crc_o     <= '0;
            busy_o    <= 1'b0;
        end else if (clear_i) begin
            state     <= S_IDLE;
            crc_q     <= INIT_REG;
            last_q    <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_ready && in_valid) begin
                        sreg     <= in_data;
                        last_q   <= in_last;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    crc_q <= crc_step;
                    sreg  <= REFLECT_IN ? (sreg >> BITS_PER_CYC) : (sreg << BITS_PER_CYC);
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        if (last_q) begin
                            crc_o     <= finalize(crc_step);
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        crc_q     <= INIT_REG;
                        in_ready  <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb_crc_stream_engine: five engine configurations driven with directed
// vectors and random messages, checked against a bit-serial CRC model.
module tb_crc_stream_engine;

    localparam int NI = 5;
    // u0 CRC-32 32b/8, u1 CRC-32 8b/8, u2 CRC-32 8b/1, u3 CCITT-FALSE 8b/8, u4 CRC-8 16b/2
    localparam int          BPW [NI] = '{4, 1, 1, 1, 2};
    localparam int          CHK [NI] = '{4, 1, 8, 1, 8};
    localparam int          CW  [NI] = '{32, 32, 32, 16, 8};
    localparam logic [63:0] PL  [NI] = '{64'h04C11DB7, 64'h04C11DB7, 64'h04C11DB7, 64'h1021, 64'h07};
    localparam logic [63:0] IV  [NI] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFF, 64'h0};
    localparam logic [63:0] XO  [NI] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0, 64'h0};
    localparam bit          RI  [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam bit          RO  [NI] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d    [NI];
    logic        v    [NI];
    logic        lst  [NI];
    logic        clr  [NI];
    logic        ordy [NI];
    logic        rdy  [NI];
    logic        ov   [NI];
    logic        bsy  [NI];
    logic [63:0] crc_x [NI];
    logic [31:0] c0, c1, c2;
    logic [15:0] c3;
    logic [7:0]  c4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign crc_x[0] = 64'(c0);
    assign crc_x[1] = 64'(c1);
    assign crc_x[2] = 64'(c2);
    assign crc_x[3] = 64'(c3);
    assign crc_x[4] = 64'(c4);

    crc_stream_engine u0 (
        .clk(clk), .rst(rst), .clear_i(clr[0]), .in_data(d[0]), .in_valid(v[0]),
        .in_last(lst[0]), .in_ready(rdy[0]), .crc_o(c0), .out_valid(ov[0]),
        .out_ready(ordy[0]), .busy_o(bsy[0])
    );

    crc_stream_engine #(.DATA_W(8)) u1 (
        .clk(clk), .rst(rst), .clear_i(clr[1]), .in_data(d[1][7:0]), .in_valid(v[1]),
        .in_last(lst[1]), .in_ready(rdy[1]), .crc_o(c1), .out_valid(ov[1]),
        .out_ready(ordy[1]), .busy_o(bsy[1])
    );

    crc_stream_engine #(.DATA_W(8), .BITS_PER_CYC(1)) u2 (
        .clk(clk), .rst(rst), .clear_i(clr[2]), .in_data(d[2][7:0]), .in_valid(v[2]),
        .in_last(lst[2]), .in_ready(rdy[2]), .crc_o(c2), .out_valid(ov[2]),
        .out_ready(ordy[2]), .busy_o(bsy[2])
    );

    crc_stream_engine #(
        .CRC_W(16), .DATA_W(8), .BITS_PER_CYC(8), .POLY(16'h1021), .INIT(16'hFFFF),
        .XOR_OUT(16'h0000), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)
    ) u3 (
        .clk(clk), .rst(rst), .clear_i(clr[3]), .in_data(d[3][7:0]), .in_valid(v[3]),
        .in_last(lst[3]), .in_ready(rdy[3]), .crc_o(c3), .out_valid(ov[3]),
        .out_ready(ordy[3]), .busy_o(bsy[3])
    );

    crc_stream_engine #(
        .CRC_W(8), .DATA_W(16), .BITS_PER_CYC(2), .POLY(8'h07), .INIT(8'h00),
        .XOR_OUT(8'h00), .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0)
    ) u4 (
        .clk(clk), .rst(rst), .clear_i(clr[4]), .in_data(d[4][15:0]), .in_valid(v[4]),
        .in_last(lst[4]), .in_ready(rdy[4]), .crc_o(c4), .out_valid(ov[4]),
        .out_ready(ordy[4]), .busy_o(bsy[4])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reverse the low w bits of x.
    function automatic logic [63:0] rev_bits(input logic [63:0] x, input int w);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < w; i++) r = (r << 1) | ((x >> i) & 64'd1);
        return r;
    endfunction

    // Textbook MSB-first CRC over the byte stream; reflected input is modelled
    // by reversing each byte, reflected output by reversing the final value.
    function automatic logic [63:0] ref_crc(input int k, input bq_t msg);
        logic [63:0] c, b, fb, mask;
        mask = (64'd1 << CW[k]) - 64'd1;
        c    = IV[k];
        foreach (msg[i]) begin
            b = RI[k] ? rev_bits(64'(msg[i]), 8) : 64'(msg[i]);
            for (int j = 7; j >= 0; j--) begin
                fb = ((c >> (CW[k] - 1)) ^ (b >> j)) & 64'd1;
                c  = (c << 1) & mask;
                if (fb != 64'd0) c = c ^ PL[k];
            end
        end
        if (RO[k]) c = rev_bits(c, CW[k]);
        return c ^ XO[k];
    endfunction

    // Send msg as words to instance k; called and returns at a negedge.
    // Non-final words also check the in_ready-low interval equals the fold count.
    task automatic send_msg(input int k, input bq_t msg, input bit final_word);
        int          nw;
        int          n;
        logic [31:0] word;
        nw = msg.size() / BPW[k];
        for (int wi = 0; wi < nw; wi++) begin
            word = '0;
            for (int bi = 0; bi < BPW[k]; bi++) begin
                if (RI[k]) word = word | (32'(msg[wi*BPW[k]+bi]) << (8*bi));
                else       word = word | (32'(msg[wi*BPW[k]+bi]) << (8*(BPW[k]-1-bi)));
            end
            d[k]   = word;
            lst[k] = final_word && (wi == nw - 1);
            v[k]   = 1'b1;
            n = 0;
            while (!rdy[k] && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!rdy[k]) check($sformatf("u%0d accept timeout", k), 64'(rdy[k]), 64'd1);
            @(negedge clk);
            v[k]   = 1'b0;
            d[k]   = $urandom();
            lst[k] = 1'($urandom());
            if (!(final_word && (wi == nw - 1))) begin
                n = 0;
                while (!rdy[k] && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("u%0d word%0d shift cycles", k, wi), 64'(n), 64'(CHK[k]));
            end
        end
    endtask

    // Wait for the result after the final word, check latency/value, hold
    // out_ready low for 'stall' cycles, then accept it.
    task automatic wait_result(input int k, input logic [63:0] exp, input string tag, input int stall);
        int n;
        int bad;
        n = 1;
        while (!ov[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(CHK[k] + 1));
        check({tag, " crc"}, crc_x[k], exp);
        bad = 0;
        repeat (stall) begin
            @(negedge clk);
            if (!ov[k] || crc_x[k] !== exp || rdy[k]) bad++;
        end
        if (stall > 0) check({tag, " hold"}, 64'(bad), 64'd0);
        ordy[k] = 1'b1;
        @(negedge clk);
        ordy[k] = 1'b0;
        check({tag, " released"}, {62'd0, ov[k], rdy[k]}, 64'd1);
    endtask

    task automatic wait_valid(input int k);
        int n;
        n = 0;
        while (!ov[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d result pending", k), 64'(ov[k]), 64'd1);
    endtask

    initial begin
        bq_t         m9, m4, m1234, rm;
        logic [63:0] exp;
        m9    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        m4    = '{8'h31, 8'h32, 8'h33, 8'h34};
        m1234 = m4;
        for (int k = 0; k < NI; k++) begin
            d[k] = '0; v[k] = 1'b0; lst[k] = 1'b0; clr[k] = 1'b0; ordy[k] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("reset outputs u0", {crc_x[0][31:0], 29'd0, rdy[0], ov[0], bsy[0]}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready after reset", 64'(rdy[0]), 64'd1);

        // Directed vectors.
        send_msg(1, m9, 1'b1);
        wait_result(1, 64'hCBF43926, "crc32 8b/8", 0);
        send_msg(2, m9, 1'b1);
        wait_result(2, 64'hCBF43926, "crc32 8b/1", 0);
        send_msg(3, m9, 1'b1);
        wait_result(3, 64'h29B1, "ccitt-false", 0);
        send_msg(0, m1234, 1'b1);
        wait_result(0, 64'h9BE3E0A3, "crc32 word 1234", 0);

        // Result held under back-pressure, then INIT reloaded.
        send_msg(1, m9, 1'b1);
        wait_result(1, 64'hCBF43926, "stall 20", 20);
        send_msg(1, m9, 1'b1);
        wait_result(1, 64'hCBF43926, "after stall", 0);

        // clear_i after four bytes of a message.
        send_msg(1, m4, 1'b0);
        check("busy mid-message", 64'(bsy[1]), 64'd1);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        check("after clear", {61'd0, rdy[1], ov[1], bsy[1]}, 64'b100);
        send_msg(1, m9, 1'b1);
        wait_result(1, 64'hCBF43926, "after clear", 0);

        // clear_i while folding, on the bit-serial engine.
        send_msg(2, m4, 1'b0);
        d[2] = 32'h35; lst[2] = 1'b0; v[2] = 1'b1;
        @(negedge clk);
        v[2] = 1'b0;
        @(negedge clk);
        clr[2] = 1'b1;
        @(negedge clk);
        clr[2] = 1'b0;
        check("clear mid-shift", {62'd0, rdy[2], bsy[2]}, 64'b10);
        send_msg(2, m9, 1'b1);
        wait_result(2, 64'hCBF43926, "after mid-shift clear", 0);

        // clear_i beats a same-cycle handshake and drops the pending result.
        send_msg(0, m1234, 1'b1);
        wait_valid(0);
        clr[0] = 1'b1; ordy[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0; ordy[0] = 1'b0;
        check("clear drops result", {62'd0, ov[0], rdy[0]}, 64'b01);
        send_msg(0, m1234, 1'b1);
        wait_result(0, 64'h9BE3E0A3, "after result clear", 0);

        // rst mid-message (u1) and mid-result-hold (u0).
        send_msg(0, m1234, 1'b1);
        wait_valid(0);
        send_msg(1, m4, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst outputs u1", {crc_x[1][31:0], 29'd0, rdy[1], ov[1], bsy[1]}, 64'd0);
        check("rst outputs u0", {crc_x[0][31:0], 30'd0, ov[0], bsy[0]}, 64'd0);
        @(negedge clk);
        check("ready after rst", 64'(rdy[1]), 64'd1);
        send_msg(1, m9, 1'b1);
        wait_result(1, 64'hCBF43926, "after rst", 0);

        // Random messages on every configuration.
        for (int k = 0; k < NI; k++) begin
            for (int t = 0; t < 6; t++) begin
                rm = {};
                repeat (BPW[k] * int'($urandom_range(1, 5))) rm.push_back(8'($urandom()));
                exp = ref_crc(k, rm);
                repeat (int'($urandom_range(0, 2))) @(negedge clk);
                send_msg(k, rm, 1'b1);
                wait_result(k, exp, $sformatf("rand u%0d #%0d", k, t), int'($urandom_range(0, 3)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
